fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, which is the PC value loaded on reset; bits [1:0] are ignored and treated as zero.
REQ-002 The block SHALL have parameter IMEM_ADDR_W, default 5, which is the width of the instruction-memory word address.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port stall, input, 1 bit: when high, PC and counter hold and redirects are ignored.
REQ-006 The block SHALL have port jumpEnable, input, 1 bit: the current instruction is J-type.
REQ-007 The block SHALL have port jumpIndex, input, 26 bits: instruction[25:0].
REQ-008 The block SHALL have port branchEnable, input, 1 bit: the current instruction is beq.
REQ-009 The block SHALL have port isZero, input, 1 bit: the ALU zero flag.
REQ-010 The block SHALL have port branchOffset, input, 32 bits: the sign-extended immediate, in words.
REQ-011 The block SHALL have port haltRequest, input, 1 bit: the current instruction is a halt.
REQ-012 The block SHALL have port imemAddress, output, IMEM_ADDR_W bits: the word address to instruction memory.
REQ-013 The block SHALL have port pc, output, 32 bits: the current byte PC.
REQ-014 The block SHALL have port pcPlus4, output, 32 bits: pc+4, combinational.
REQ-015 The block SHALL have port fetchValid, output, 1 bit: the instruction at pc is live and may retire this cycle.
REQ-016 The block SHALL have port halted, output, 1 bit: the block is in HALT.
REQ-017 The block SHALL have port retiredCount, output, 32 bits: the count of retired instructions.

Function
REQ-018 The FSM SHALL have states RESET_HOLD, RUN and HALT, with RESET_HOLD entered while reset is high.
REQ-019 The FSM SHALL transition RESET_HOLD->RUN unconditionally on the first edge with reset low; fetchValid=0 in RESET_HOLD.
REQ-020 The FSM SHALL transition RUN->HALT on an edge with haltRequest=1 and stall=0; the PC does not update on that edge.
REQ-021 HALT SHALL be exited only by reset; in HALT, pc, retiredCount and imemAddress are frozen, all inputs are ignored, fetchValid=0 and halted=1.
REQ-022 In RUN, fetchValid SHALL equal ~stall; an instruction retires on an edge when fetchValid=1 and haltRequest=0.
REQ-023 Next-PC on a retiring edge SHALL use priority jump > taken branch (branchEnable & isZero) > pcPlus4.
REQ-024 The jump target SHALL be {pcPlus4[31:28], jumpIndex, 2'b00}.
REQ-025 The branch target SHALL be pcPlus4 + (branchOffset << 2), computed modulo 2^32 with no overflow detection.
REQ-026 pcPlus4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000.
REQ-027 imemAddress SHALL equal pc[IMEM_ADDR_W+1:2]; upper PC bits are not checked, so the address aliases.
REQ-028 retiredCount SHALL increment by 1 on each retiring edge and wrap at 2^32.
REQ-029 When stall=1, the block SHALL hold all state and discard any jump, branch or halt presented that cycle.
REQ-030 pc[1:0] SHALL always be 0.

Reset
REQ-031 While reset is high at an edge, the block SHALL load pc=RESET_PC & ~3, retiredCount=0 and state=RESET_HOLD, overriding stall and all other inputs.
REQ-032 Reset asserted mid-operation, including while in HALT, SHALL take effect on that edge; outputs after that edge are fetchValid=0, halted=0, imemAddress=RESET_PC[IMEM_ADDR_W+1:2].

Structure
REQ-033 The FSM state encoding (2-bit typedef) and the constant PC_STEP=4 SHALL live in the shared CPU package.
REQ-034 The next-PC selection SHALL be a combinational sub-module named next_pc_logic; the PC register, FSM and counter stay in fetch_unit.

Verification
REQ-035 Scenario: reset for 2 cycles, then 4 idle cycles -> cycle 1 has fetchValid=0; then pc = 0, 4, 8, 12; retiredCount=3.
REQ-036 Scenario: pc=0x10, branchEnable=1, isZero=1, branchOffset=0xFFFF_FFFD -> next pc=0x08; with isZero=0 -> next pc=0x14.
REQ-037 Scenario: pc=0x4000_0020, jumpEnable=1, branchEnable=1, isZero=1, jumpIndex=0x40 -> next pc=0x4000_0100, so the jump wins.
REQ-038 Scenario: stall=1 for 3 cycles with jumpEnable=1 -> pc and retiredCount are unchanged and fetchValid=0; after release, the redirect applies only if still asserted.
REQ-039 Scenario: haltRequest=1 at pc=0x1C -> halted=1 next cycle, pc stays 0x1C with no further count; then reset -> pc=RESET_PC and halted=0.
REQ-040 Scenario: pc=0xFFFF_FFFC with no redirect -> next pc=0x0; and with IMEM_ADDR_W=5 and pc=0x84 -> imemAddress=1.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared CPU package: fetch FSM state encoding, PC step constant and
// a word-alignment helper used wherever a byte PC is produced.
package fetch_unit_pkg;

   typedef enum logic [1:0] {
      RESET_HOLD = 2'b00,
      RUN        = 2'b01,
      HALT       = 2'b10
   } fetch_state_e;

   localparam logic [31:0] PC_STEP = 32'd4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: redirect/stall controls from the core (master) and
// PC / retirement status back from the fetch unit (slave).
interface fetch_unit_if #(
   parameter int IMEM_ADDR_W = 5
);
   logic                   stall;
   logic                   jumpEnable;
   logic [25:0]            jumpIndex;
   logic                   branchEnable;
   logic                   isZero;
   logic [31:0]            branchOffset;
   logic                   haltRequest;
   logic [IMEM_ADDR_W-1:0] imemAddress;
   logic [31:0]            pc;
   logic [31:0]            pcPlus4;
   logic                   fetchValid;
   logic                   halted;
   logic [31:0]            retiredCount;

   modport master (
      output stall, jumpEnable, jumpIndex, branchEnable, isZero,
             branchOffset, haltRequest,
      input  imemAddress, pc, pcPlus4, fetchValid, halted, retiredCount
   );

   modport slave (
      input  stall, jumpEnable, jumpIndex, branchEnable, isZero,
             branchOffset, haltRequest,
      output imemAddress, pc, pcPlus4, fetchValid, halted, retiredCount
   );
endinterface

// File: rtl/fetch_unit_next_pc_logic.sv
// Combinational next-PC select: jump beats taken branch beats sequential.
module next_pc_logic
   import fetch_unit_pkg::*;
(
   input  logic [31:0] pc_plus4_i,
   input  logic        jump_enable_i,
   input  logic [25:0] jump_index_i,
   input  logic        branch_enable_i,
   input  logic        is_zero_i,
   input  logic [31:0] branch_offset_i,
   output logic [31:0] next_pc_o
);

   logic [31:0] jump_target;
   logic [31:0] branch_target;

   assign jump_target   = {pc_plus4_i[31:28], jump_index_i, 2'b00};
   // Offset is in words; the add wraps modulo 2^32 by construction.
   assign branch_target = pc_plus4_i + {branch_offset_i[29:0], 2'b00};

   // Priority select of the redirect target.
   always_comb begin
      next_pc_o = pc_plus4_i;
      if (jump_enable_i) begin
         next_pc_o = word_align(jump_target);
      end else if (branch_enable_i && is_zero_i) begin
         next_pc_o = word_align(branch_target);
      end else begin
         next_pc_o = word_align(pc_plus4_i);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Fetch unit: PC register, RESET_HOLD/RUN/HALT sequencer and retired-
// instruction counter; next-PC selection is delegated to next_pc_logic.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC    = 32'h0000_0000,
   parameter int          IMEM_ADDR_W = 5
) (
   input  logic          CLK,
   input  logic          reset,
   fetch_unit_if.slave   bus
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  count_q, count_d;

   logic [31:0]  pc_plus4;
   logic [31:0]  next_pc;
   logic         fetch_valid;
   logic         retire;

   assign pc_plus4    = pc_q + PC_STEP;
   assign fetch_valid = (state_q == RUN) && !bus.stall;
   assign retire      = fetch_valid && !bus.haltRequest;

   next_pc_logic u_next_pc (
      .pc_plus4_i      (pc_plus4),
      .jump_enable_i   (bus.jumpEnable),
      .jump_index_i    (bus.jumpIndex),
      .branch_enable_i (bus.branchEnable),
      .is_zero_i       (bus.isZero),
      .branch_offset_i (bus.branchOffset),
      .next_pc_o       (next_pc)
   );

   // Sequencer next state plus PC/counter update on retiring edges only.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      count_d = count_q;
      case (state_q)
         RESET_HOLD: state_d = RUN;
         RUN: begin
            if (!bus.stall && bus.haltRequest) begin
               state_d = HALT;
            end else begin
               state_d = RUN;
            end
         end
         HALT:    state_d = HALT;
         default: state_d = RESET_HOLD;
      endcase
      if (retire) begin
         pc_d    = next_pc;
         count_d = count_q + 32'd1;
      end else begin
         pc_d    = pc_q;
         count_d = count_q;
      end
   end

   // State registers; reset dominates stall and every other input.
   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q <= RESET_HOLD;
         pc_q    <= word_align(RESET_PC);
         count_q <= 32'd0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         count_q <= count_d;
      end
   end

   assign bus.pc           = pc_q;
   assign bus.pcPlus4      = pc_plus4;
   assign bus.imemAddress  = pc_q[IMEM_ADDR_W+1:2];
   assign bus.fetchValid   = fetch_valid;
   assign bus.halted       = (state_q == HALT);
   assign bus.retiredCount = count_q;

endmodule
